// File: rtl/right_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_register
// Description : Serial-in, parallel-out right-shift register. Each enabled
//               rising edge inserts the serial bit at the MSB and moves every
//               stored bit one place toward the LSB. The oldest bit falls off
//               the LSB end. The whole register is driven onto the parallel
//               output with no combinational path from the inputs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH  : number of register bits (DEPTH >= 1), default 8
// Ports
//   clk    : in  1     rising-edge clock
//   reset  : in  1     synchronous reset, active low; clears all bits
//   enable : in  1     shift enable, active high; register holds when low
//   in     : in  1     serial data bit inserted at out[DEPTH-1]
//   out    : out DEPTH parallel contents; out[DEPTH-1] newest, out[0] oldest
// ============================================================================
module right_shift_register #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  output logic [DEPTH-1:0] out
);

  logic [DEPTH-1:0] r_shift;
  logic [DEPTH-1:0] w_shift_next;

  // The shifted-in value is built separately for a single-bit register,
  // because the slice out[DEPTH-1:1] does not exist when DEPTH is 1.
  generate
    if (DEPTH == 1) begin : g_single_bit
      assign w_shift_next = in;
    end else begin : g_multi_bit
      assign w_shift_next = {in, r_shift[DEPTH-1:1]};
    end
  endgenerate

  // Reset outranks enable; with enable low the register simply holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift <= '0;
    end else if (enable) begin
      r_shift <= w_shift_next;
    end
  end

  assign out = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_right_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_right_shift_register
// Description : Directed bench for right_shift_register at DEPTH 8, 1 and 4.
//               The stimulus process queues the expected output for every
//               edge it drives; a separate monitor pops the queue after each
//               rising edge and compares it with the selected instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_right_shift_register;

  localparam int c_sel8 = 0;
  localparam int c_sel1 = 1;
  localparam int c_sel4 = 2;

  typedef struct {
    int         sel;
    logic [7:0] exp;
  } sb_entry_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       din;
  logic [7:0] out8;
  logic [0:0] out1;
  logic [3:0] out4;

  sb_entry_t  sb[$];
  int         checks;
  int         errors;
  bit         done;

  right_shift_register #(.DEPTH(8)) u_dut8 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (din),
    .out    (out8)
  );

  right_shift_register #(.DEPTH(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (din),
    .out    (out1)
  );

  right_shift_register #(.DEPTH(4)) u_dut4 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (din),
    .out    (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs on the falling edge and queue what the selected
  // instance must show right after the following rising edge.
  task automatic step(input logic rst_n, input logic en, input logic b,
                      input int sel, input logic [7:0] exp);
    sb_entry_t e;
    @(negedge clk);
    reset  = rst_n;
    enable = en;
    din    = b;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: every output is registered, so sample 1 time unit after the edge.
  always @(posedge clk) begin
    sb_entry_t  e;
    logic [7:0] got;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        c_sel8:  got = out8;
        c_sel1:  got = {7'b0, out1};
        default: got = {4'b0, out4};
      endcase
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL check %0d sel %0d: out got %b required %b",
                 checks, e.sel, got, e.exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: stimulus did not complete");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    done   = 1'b0;
    reset  = 1'b0;
    enable = 1'b0;
    din    = 1'b0;

    // Reset then shift 1,0,1,0.
    step(1'b0, 1'b0, 1'b0, c_sel8, 8'b0000_0000);
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1000_0000);
    step(1'b1, 1'b1, 1'b0, c_sel8, 8'b0100_0000);
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1010_0000);
    step(1'b1, 1'b1, 1'b0, c_sel8, 8'b0101_0000);

    // Reset mid-operation while enable=1, in=1.
    step(1'b0, 1'b1, 1'b1, c_sel8, 8'b0000_0000);

    // Full pattern fill 1,1,0,1,0,1,1.
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1000_0000);
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1100_0000);
    step(1'b1, 1'b1, 1'b0, c_sel8, 8'b0110_0000);
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1011_0000);
    step(1'b1, 1'b1, 1'b0, c_sel8, 8'b0101_1000);
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1010_1100);
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1101_0110);

    // Enable low holds a populated register.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, c_sel8, 8'b1101_0110);

    // Enable low holds the cleared register with in=1.
    step(1'b0, 1'b0, 1'b0, c_sel8, 8'b0000_0000);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, c_sel8, 8'b0000_0000);

    // Reset priority over enable on the same edge, from a non-zero state.
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1000_0000);
    step(1'b0, 1'b1, 1'b1, c_sel8, 8'b0000_0000);

    // First shift after release: in at MSB, zeros below.
    step(1'b1, 1'b1, 1'b1, c_sel8, 8'b1000_0000);

    // DEPTH = 1: in 1 then 0.
    step(1'b0, 1'b0, 1'b0, c_sel1, 8'b0000_0000);
    step(1'b1, 1'b1, 1'b1, c_sel1, 8'b0000_0001);
    step(1'b1, 1'b1, 1'b0, c_sel1, 8'b0000_0000);
    step(1'b1, 1'b1, 1'b1, c_sel1, 8'b0000_0001);
    step(1'b1, 1'b0, 1'b0, c_sel1, 8'b0000_0001);

    // DEPTH = 4: shift 1,0,0,0,0; the bit walks out of the LSB end.
    step(1'b0, 1'b0, 1'b0, c_sel4, 8'b0000_0000);
    step(1'b1, 1'b1, 1'b1, c_sel4, 8'b0000_1000);
    step(1'b1, 1'b1, 1'b0, c_sel4, 8'b0000_0100);
    step(1'b1, 1'b1, 1'b0, c_sel4, 8'b0000_0010);
    step(1'b1, 1'b1, 1'b0, c_sel4, 8'b0000_0001);
    step(1'b1, 1'b1, 1'b0, c_sel4, 8'b0000_0000);

    // Let the monitor drain the last entry.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: entries left %0d required 0", sb.size());
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
